// File: rtl/conv_pkg.sv
// Shared types and helpers for the 1-D convolution engine.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic PAD_VALID = 1'b0;
  localparam logic PAD_SAME  = 1'b1;

  // Number of outputs produced for an effective kernel length k.
  function automatic int unsigned calc_n_out(int unsigned depth, int unsigned k, logic pad);
    return (pad == PAD_SAME) ? depth : depth - k + 1;
  endfunction

endpackage

// File: rtl/conv_sram.sv
// Single-port memory with synchronous one-cycle read; writes win over reads.
module conv_sram
  import conv_pkg::*;
#(
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned DEPTH  = 64,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[addr] <= wdata;
    else if (re)
      rdata <= mem[addr];
  end

endmodule

// File: rtl/conv1d_engine.sv
// Signed 1-D convolution over loadable input/weight memories, streaming results
// on a valid/ready port with runtime kernel length, padding mode and ReLU.
module conv1d_engine
  import conv_pkg::*;
#(
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned ACC_W  = 20,
  parameter  int unsigned DEPTH  = 64,
  parameter  int unsigned K_MAX  = 8,
  localparam int unsigned ADDR_W = $clog2(DEPTH),
  localparam int unsigned KW     = $clog2(K_MAX) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_we,
  input  logic              ld_sel,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [KW-1:0]     cfg_k,
  input  logic              cfg_pad,
  input  logic              cfg_relu,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic [ADDR_W-1:0] out_idx
);

  localparam int unsigned IW = ADDR_W + 2;

  state_t                    state;
  logic [KW-1:0]             k_q, t_q, k_eff, off;
  logic                      pad_q, relu_q, tap_v_q;
  logic [ADDR_W-1:0]         j_q, n_last, in_addr, w_addr;
  logic signed [ACC_W-1:0]   acc_q, acc_add, acc_d, res;
  logic signed [IW-1:0]      idx;
  logic                      in_range, rd_en, in_we, w_we;
  logic signed [DATA_W-1:0]  in_rd, w_rd;
  logic signed [2*DATA_W-1:0] prod;

  assign busy      = (state == MAC) || (state == EMIT);
  assign done      = (state == DONE);
  assign out_valid = (state == EMIT);

  always_comb begin
    k_eff = cfg_k;
    if (cfg_k == '0)
      k_eff = KW'(1);
    else if (cfg_k > KW'(K_MAX))
      k_eff = KW'(K_MAX);

    off      = (pad_q == PAD_SAME) ? ((k_q - KW'(1)) >> 1) : '0;
    idx      = $signed(IW'(j_q)) + $signed(IW'(t_q)) - $signed(IW'(off));
    in_range = !idx[IW-1] && (idx[IW-2:0] < (IW-1)'(DEPTH));
    // Out-of-range taps issue no read; tap_v_q later masks the stale read data.
    rd_en    = (state == MAC) && (t_q < k_q) && in_range;

    in_we   = (state == IDLE) && ld_we && !ld_sel;
    w_we    = (state == IDLE) && ld_we &&  ld_sel;
    in_addr = (state == IDLE) ? ld_addr : idx[ADDR_W-1:0];
    w_addr  = (state == IDLE) ? ld_addr : ADDR_W'(t_q);

    prod    = in_rd * w_rd;
    acc_add = tap_v_q ? {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod} : '0;
    acc_d   = acc_q + acc_add;
    res     = (relu_q && acc_d[ACC_W-1]) ? '0 : acc_d;
    n_last  = ADDR_W'(calc_n_out(DEPTH, 32'(k_q), pad_q) - 1);
  end

  conv_sram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_in_mem (
    .clk  (clk),
    .we   (in_we),
    .re   (rd_en),
    .addr (in_addr),
    .wdata(ld_data),
    .rdata(in_rd)
  );

  conv_sram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_w_mem (
    .clk  (clk),
    .we   (w_we),
    .re   (rd_en),
    .addr (w_addr),
    .wdata(ld_data),
    .rdata(w_rd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      k_q      <= '0;
      t_q      <= '0;
      pad_q    <= 1'b0;
      relu_q   <= 1'b0;
      tap_v_q  <= 1'b0;
      j_q      <= '0;
      acc_q    <= '0;
      out_data <= '0;
      out_idx  <= '0;
    end else begin
      tap_v_q <= rd_en;
      case (state)
        IDLE: if (start) begin
          k_q    <= k_eff;
          pad_q  <= cfg_pad;
          relu_q <= cfg_relu;
          j_q    <= '0;
          t_q    <= '0;
          acc_q  <= '0;
          state  <= MAC;
        end
        MAC: begin
          acc_q <= acc_d;
          // t_q == k_q is the drain cycle that absorbs the last read.
          if (t_q == k_q) begin
            out_data <= res;
            out_idx  <= j_q;
            state    <= EMIT;
          end else begin
            t_q <= t_q + KW'(1);
          end
        end
        EMIT: if (out_ready) begin
          if (j_q == n_last) begin
            state <= DONE;
          end else begin
            j_q   <= j_q + ADDR_W'(1);
            t_q   <= '0;
            acc_q <= '0;
            state <= MAC;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv1d_engine.sv
// Directed bench for conv1d_engine: table of runs plus backpressure/misuse/reset sequences.
module tb_conv1d_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_we, ld_sel;
  logic [5:0]  ld_addr;
  logic [7:0]  ld_data;
  logic [3:0]  cfg_k;
  logic        cfg_pad, cfg_relu, start;
  logic        busy, done, out_valid, out_ready;
  logic [19:0] out_data;
  logic [5:0]  out_idx;

  int checks = 0;
  int errors = 0;
  int ref_in [64];
  int ref_w  [64];
  logic [19:0] got [64];

  always #5 clk = ~clk;

  conv1d_engine #(.DATA_W(8), .ACC_W(20), .DEPTH(64), .K_MAX(8)) dut (
    .clk(clk), .reset(reset), .ld_we(ld_we), .ld_sel(ld_sel), .ld_addr(ld_addr),
    .ld_data(ld_data), .cfg_k(cfg_k), .cfg_pad(cfg_pad), .cfg_relu(cfg_relu),
    .start(start), .busy(busy), .done(done), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx)
  );

  typedef struct {
    int setup; int k; bit pad; bit relu;
    int n_out; int cycles; int v_first; int v_last;
  } vec_t;

  vec_t tab [7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int exp_val(int k, bit pad, bit relu, int j);
    int keff, off, sum, ix;
    keff = (k == 0) ? 1 : ((k > 8) ? 8 : k);
    off  = pad ? (keff - 1) / 2 : 0;
    sum  = 0;
    for (int t = 0; t < keff; t++) begin
      ix = j + t - off;
      if (ix >= 0 && ix < 64) sum += ref_in[ix] * ref_w[t];
    end
    if (relu && sum < 0) sum = 0;
    return sum;
  endfunction

  task automatic load_setup(input int s);
    for (int i = 0; i < 64; i++) begin
      case (s)
        0: begin ref_in[i] = i;    ref_w[i] = (i < 3) ? 1 : 0; end
        1: begin ref_in[i] = i;    ref_w[i] = (i == 1) ? 2 : ((i == 0 || i == 2) ? 1 : 0); end
        2: begin ref_in[i] = -5;   ref_w[i] = (i == 0) ? 3 : 0; end
        default: begin ref_in[i] = -128; ref_w[i] = -128; end
      endcase
    end
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 64; i++) begin
        @(negedge clk);
        ld_we   = 1'b1;
        ld_sel  = m[0];
        ld_addr = 6'(i);
        ld_data = (m == 0) ? 8'(ref_in[i]) : 8'(ref_w[i]);
      end
    end
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  task automatic run_conv(input int k, input bit pad, input bit relu, input int stall,
                          input bit misuse, input int abort_at,
                          output int n_res, output int cyc);
    int stall_left;
    logic [19:0] held;
    bit aborted;
    n_res = 0; cyc = 0; aborted = 0; stall_left = stall; held = '0;
    @(negedge clk);
    cfg_k = 4'(k); cfg_pad = pad; cfg_relu = relu; start = 1'b1;
    out_ready = (stall == 0);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    chk("busy_after_start", int'(busy), 1);
    while (!done && !aborted && cyc < 5000) begin
      if (misuse) begin
        start   = (cyc == 4);
        ld_we   = (cyc == 4 || cyc == 5);
        ld_sel  = (cyc == 5);
        ld_addr = 6'd5;
        ld_data = 8'd100;
      end
      if (abort_at >= 0 && out_valid && int'(out_idx) == abort_at) begin
        reset = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_valid", int'(out_valid), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_data", int'(out_data), 0);
        @(negedge clk);
        reset = 1'b1;
        aborted = 1;
      end else if (out_valid) begin
        if (stall > 0 && n_res == 0) begin
          if (stall_left == stall) held = out_data;
          else chk("stall_hold", int'(out_data), int'(held));
        end
        if (stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
          chk($sformatf("out_idx_%0d", n_res), int'(out_idx), n_res);
          if (n_res < 64) got[n_res] = out_data;
          n_res++;
        end
      end
      if (!aborted) begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0; ld_we = 1'b0; out_ready = 1'b1;
    if (!aborted) begin
      chk("done_seen", int'(done), 1);
      if (done) chk("busy_at_done", int'(busy), 0);
    end
  endtask

  task automatic verify(input int k, input bit pad, input bit relu, input int n);
    for (int j = 0; j < n && j < 64; j++)
      chk($sformatf("res_%0d", j), int'($signed(got[j])), exp_val(k, pad, relu, j));
  endtask

  initial begin
    int n, c, cur;
    tab[0] = '{0,  3, 1'b0, 1'b0, 62, 311, 3,        186};
    tab[1] = '{1,  3, 1'b1, 1'b0, 64, 321, 1,        188};
    tab[2] = '{2,  1, 1'b0, 1'b1, 64, 193, 0,        0};
    tab[3] = '{2,  1, 1'b0, 1'b0, 64, 193, 'hFFFF1,  'hFFFF1};
    tab[4] = '{3,  8, 1'b0, 1'b0, 57, 571, 131072,   131072};
    tab[5] = '{3, 12, 1'b0, 1'b0, 57, 571, 131072,   131072};
    tab[6] = '{3,  0, 1'b0, 1'b0, 64, 193, 16384,    16384};

    reset = 1'b0; ld_we = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
    cfg_k = '0; cfg_pad = 1'b0; cfg_relu = 1'b0; start = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_idx", int'(out_idx), 0);
    reset = 1'b1;

    cur = -1;
    for (int i = 0; i < 7; i++) begin
      if (tab[i].setup != cur) begin
        load_setup(tab[i].setup);
        cur = tab[i].setup;
      end
      run_conv(tab[i].k, tab[i].pad, tab[i].relu, 0, 1'b0, -1, n, c);
      chk($sformatf("v%0d_n_out", i), n, tab[i].n_out);
      chk($sformatf("v%0d_cycles", i), c, tab[i].cycles);
      chk($sformatf("v%0d_first", i), int'(got[0]), tab[i].v_first);
      chk($sformatf("v%0d_last", i), int'(got[tab[i].n_out - 1]), tab[i].v_last);
      if (i == 1) chk("same_out1", int'(got[1]), 4);
      verify(tab[i].k, tab[i].pad, tab[i].relu, n);
    end

    // Backpressure on output 0 with start/ld_we pulsed mid-run.
    load_setup(0);
    run_conv(3, 1'b0, 1'b0, 10, 1'b1, -1, n, c);
    chk("bp_n_out", n, 62);
    chk("bp_cycles", c, 321);
    verify(3, 1'b0, 1'b0, n);

    // Abort during output 10, then rerun without reloading.
    run_conv(3, 1'b0, 1'b0, 0, 1'b0, 10, n, c);
    chk("abort_count", n, 10);
    @(negedge clk);
    run_conv(3, 1'b0, 1'b0, 0, 1'b0, -1, n, c);
    chk("rerun_n_out", n, 62);
    chk("rerun_cycles", c, 311);
    chk("rerun_last", int'(got[61]), 186);
    verify(3, 1'b0, 1'b0, n);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
